// File: rtl/pipe_adder.sv
`timescale 1ns/1ps
// Pipelined WIDTH-bit add/subtract; the carry chain is cut into STAGES segments with a register after each.
// Latency STAGES-1 cycles after the accept edge; a stalled output freezes every stage (in_ready = out_ready | ~out_valid).
module pipe_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int SEG = WIDTH / STAGES;

    // r_a/r_b hold the not-yet-added operand bits, shifted down so the next segment sits at [SEG-1:0].
    logic             r_v   [STAGES];
    logic             r_c   [STAGES];
    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_b   [STAGES];
    logic [WIDTH-1:0] r_s   [STAGES];
    logic             r_ovf;

    logic             w_en;
    logic             w_vin [STAGES];
    logic             w_cin [STAGES];
    logic [WIDTH-1:0] w_opa [STAGES];
    logic [WIDTH-1:0] w_opb [STAGES];
    logic [WIDTH-1:0] w_sin [STAGES];
    logic [SEG-1:0]   w_seg [STAGES];
    logic             w_co  [STAGES];
    logic             w_ovf;
    logic             w_unused;

    assign w_en      = out_ready | ~r_v[STAGES-1];
    assign in_ready  = w_en;
    assign out_valid = r_v[STAGES-1];
    assign s         = r_s[STAGES-1];
    assign cout      = r_c[STAGES-1];
    assign ovf       = r_ovf;
    assign w_unused  = ^{r_a[STAGES-1], r_b[STAGES-1]};

    always_comb begin
        w_vin[0] = in_valid;
        w_cin[0] = cin ^ sub;
        w_opa[0] = a;
        w_opb[0] = b ^ {WIDTH{sub}};
        w_sin[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            w_vin[k] = r_v[k-1];
            w_cin[k] = r_c[k-1];
            w_opa[k] = r_a[k-1];
            w_opb[k] = r_b[k-1];
            w_sin[k] = r_s[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            {w_co[k], w_seg[k]} = {1'b0, w_opa[k][SEG-1:0]} + {1'b0, w_opb[k][SEG-1:0]}
                                + (SEG+1)'(w_cin[k]);
        end
        // Carry into the MSB is recovered from the MSB sum bit: a ^ b' ^ sum.
        w_ovf = w_opa[STAGES-1][SEG-1] ^ w_opb[STAGES-1][SEG-1]
              ^ w_seg[STAGES-1][SEG-1] ^ w_co[STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k] <= 1'b0;
                r_c[k] <= 1'b0;
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
            end
            r_ovf <= 1'b0;
        end else if (w_en) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k] <= w_vin[k];
                r_c[k] <= w_co[k];
                r_a[k] <= w_opa[k] >> SEG;
                r_b[k] <= w_opb[k] >> SEG;
                r_s[k] <= w_sin[k] | (WIDTH'(w_seg[k]) << (k * SEG));
            end
            r_ovf <= w_ovf;
        end
    end
endmodule

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined add/subtract unit for the arithmetic datapath; generalises the 8-bit ripple adder to any width. The carry chain is split into STAGES equal segments with a register between segments, so one operation is accepted per cycle at a shorter critical path. The unit adds subtract mode, signed-overflow detection and a valid/ready handshake with backpressure.

## Interface

- WIDTH, 8, operand/result width in bits; must be a multiple of STAGES
- STAGES, 2, pipeline depth and carry-chain segment count; 1..WIDTH; segment width SEG = WIDTH/STAGES

- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  operands a, b, cin, sub present
- in_ready  out  1  unit can accept operands this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (add) / borrow-in (subtract)
- sub  in  1  0 = add, 1 = subtract
- out_valid  out  1  s, cout, ovf hold a result
- out_ready  in  1  downstream accepts result
- s  out  WIDTH  sum/difference, mod 2^WIDTH
- cout  out  1  carry out of bit WIDTH-1
- ovf  out  1  two's-complement signed overflow

## Operation

- Effective operands: b' = b XOR {WIDTH{sub}}, c0 = cin XOR sub. Result {cout, s} = a + b' + c0, computed in WIDTH+1 bits.
  - sub=0, cin=0: a+b; sub=0, cin=1: a+b+1.
  - sub=1, cin=0: a−b; sub=1, cin=1: a−b−1 (borrow-in).
  - When subtracting, cout=1 means no borrow and cout=0 means borrow.
- ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- Stage k (0..STAGES-1) computes bits [k*SEG +: SEG] from the registered carry of stage k−1 (stage 0 uses c0).
  - Upper operand segments are delayed to meet their stage.
  - Lower result segments are delayed to align with the final stage.
  - Each stage holds a valid bit.
- The last stage's registers drive s, cout and ovf directly. No combinational path from inputs to outputs, except when STAGES=1, where the single register stage still isolates them.
- Global advance enable: en = out_ready OR NOT out_valid.
  - in_ready = en (combinational from out_ready and out_valid).
  - On en, every stage loads from its predecessor; stage 0 valid loads in_valid.
  - Bubbles are not collapsed.
- Transfer in occurs when in_valid AND in_ready. Transfer out occurs when out_valid AND out_ready.
- Results emerge in acceptance order, with no loss and no duplication.

## Timing

- Reset: all stage valid bits = 0, all data registers = 0.
  - Outputs during and after reset: out_valid=0, s=0, cout=0, ovf=0.
  - in_ready=1 from the first cycle after reset deassertion.
- Reset asserted mid-operation: all in-flight operations are discarded immediately (asynchronous). Nothing is emitted for them afterward.
- Latency: operands accepted at edge N appear with out_valid=1 after edge N+STAGES−1. Example: STAGES=2 gives results valid the cycle after acceptance; with STAGES=1 they are valid immediately after the accept edge.
- Throughput: 1 result per cycle while out_ready=1.
- Stall: while out_valid=1 and out_ready=0:
  - s, cout, ovf and out_valid hold stable.
  - in_ready=0, and the whole pipeline freezes.
  - Inputs presented during the stall are not captured.
- Simultaneous transfer in and out in one cycle is legal and is the normal streaming case.
- in_valid=0 while en=1 inserts a bubble; stage 0 valid=0.

## Test plan

- Reset: assert rst mid-stream with 2 operations in flight (WIDTH=8, STAGES=2) → out_valid, s, cout, ovf all 0 immediately. After deassertion no stale result appears and in_ready=1.
- Carry across segment boundary: a=0xFF, b=0x01, cin=0, sub=0 → s=0x00, cout=1, ovf=0, exactly STAGES−1 cycles after the accept edge. Also a=0x0F, b=0x01 → s=0x10, cout=0.
- Overflow: a=0x7F, b=0x01, add → s=0x80, cout=0, ovf=1. a=0x80, b=0x01, sub=1, cin=0 → s=0x7F, cout=1, ovf=1.
- Subtract/borrow: a=0x05, b=0x07, sub=1, cin=0 → s=0xFE, cout=0, ovf=0. Same operands with cin=1 → s=0xFD.
- Backpressure: stream 6 operations, hold out_ready=0 for 3 cycles mid-stream → outputs frozen, in_ready=0. All 6 results are delivered in order, each exactly once.
- Parameter sweep: (WIDTH,STAGES) = (8,1), (16,4), (32,8) with 1000 random operands each, random in_valid/out_ready and random sub/cin → every result matches a behavioural {cout,s} = a + (b^sub) + (cin^sub) model, with ovf matching.
